// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive sequencer steering an external edge/bit counter, sampler, checkers and deserializer.
// Latency: data_valid/frame_err pulse one CLK after STOP edge 7, i.e. 8*(DATA_WIDTH+2[+1 parity]) CLKs after start detect.
// Backpressure: none; the serial line cannot be stalled, every frame is sequenced and reported exactly once.
// Parity support (PAR_EN, par_err, par_chk_en, PARITY state) is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
`ifdef UART_RX_PARITY_EN
    input  logic       PAR_EN,
    input  logic       par_err,
    output logic       par_chk_en,
`endif
    input  logic [3:0] bit_cnt,
    input  logic [2:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       stp_err,
    output logic       cnt_enable,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       frame_err
);

    // The start bit is bit index 0, so the last data bit carries index DATA_WIDTH.
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   data_valid_nxt;
    logic   frame_err_nxt;

    // Checker results are only meaningful on the last oversampling edge of a bit.
    logic   edge_last;
    logic   edge_chk;

    assign edge_last = (edge_cnt == 3'd7);
    assign edge_chk  = (edge_cnt == 3'd6);

`ifdef UART_RX_PARITY_EN
    // PAR_EN is frozen for the whole frame; parity errors accumulate until the stop bit.
    logic par_en_q;
    logic par_en_nxt;
    logic par_flag;
    logic par_flag_nxt;
`endif

    // State, frame-level flags and the registered result pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q   <= 1'b0;
            par_flag   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            data_valid <= data_valid_nxt;
            frame_err  <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            par_en_q   <= par_en_nxt;
            par_flag   <= par_flag_nxt;
`endif
        end
    end

    // Next-state decode plus the decoded strobes; transitions out of a bit happen only on edge 7
    // so the external counter always wraps back to 0 before the enable changes.
    always_comb begin
        state_nxt      = state;
        data_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        cnt_enable     = 1'b0;
        dat_samp_en    = 1'b0;
        strt_chk_en    = 1'b0;
        stp_chk_en     = 1'b0;
        deser_en       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk_en     = 1'b0;
        par_en_nxt     = par_en_q;
        par_flag_nxt   = par_flag;
`endif

        case (state)
            IDLE: begin
                // Level detect: a line already low at reset release starts a frame immediately.
                if (!RX_IN) begin
                    state_nxt = START;
`ifdef UART_RX_PARITY_EN
                    par_en_nxt   = PAR_EN;
                    par_flag_nxt = 1'b0;
`endif
                end
            end

            START: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = edge_chk;
                if (edge_last) begin
                    // A glitch aborts silently: no result pulse of either kind.
                    state_nxt = strt_glitch ? IDLE : DATA;
                end
            end

            DATA: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = edge_last;
                if (edge_last && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = par_en_q ? PARITY : STOP;
`else
                    state_nxt = STOP;
`endif
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = edge_chk;
                if (edge_last) begin
                    par_flag_nxt = par_flag | par_err;
                    state_nxt    = STOP;
                end
            end
`endif

            STOP: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = edge_chk;
                if (edge_last) begin
                    state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (stp_err || par_flag) begin
`else
                    if (stp_err) begin
`endif
                        frame_err_nxt = 1'b1;
                    end else begin
                        data_valid_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
